// File: rtl/riscv_pkg.sv
// Shared definitions for the memory arbiter: FSM encoding, default sizes,
// and the word-address range check used by both ports.
package riscv_pkg;

  localparam int unsigned ADDR_WORDS_DEF = 4096;
  localparam int unsigned AW_DEF         = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_F = 2'd1,
    RESP_D = 2'd2
  } arb_state_t;

  // True when the word address (byte address bits [31:2]) lies beyond the RAM.
  function automatic logic word_oor(input logic [29:0] word, input int unsigned words);
    return word >= 30'(words);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin winner select; purely combinational, the last-grant
// flag is owned by the caller.
module rr_arb2 (
  input  logic req_f,
  input  logic req_d,
  input  logic last_f,
  output logic gnt_f,
  output logic gnt_d
);

  // On a conflict the port that did not win last time is chosen.
  always_comb begin
    gnt_d = req_d & (~req_f | last_f);
    gnt_f = req_f & (~req_d | ~last_f);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shared single-port RAM arbiter between an instruction-fetch port and a
// load/store port: grant in IDLE, respond in the following cycle.
module mem_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_WORDS = ADDR_WORDS_DEF,
  parameter int unsigned AW         = AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          f_req,
  input  logic [31:0]   f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  input  logic          d_req,
  input  logic [31:0]   d_addr,
  input  logic [3:0]    d_wmask,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_done,
  output logic          d_err,
  output logic [31:0]   rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_ren,
  output logic [3:0]    mem_wmask,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  arb_state_t state, state_nx;
  logic       last_f, last_f_nx;
  logic       rsp_err, rsp_err_nx;
  logic       rsp_wr, rsp_wr_nx;
  logic       win_f, win_d;
  logic       f_oor, d_oor;
  logic       unused_lsbs;

  assign unused_lsbs = ^{f_addr[1:0], d_addr[1:0]};
  assign f_oor = word_oor(f_addr[31:2], ADDR_WORDS);
  assign d_oor = word_oor(d_addr[31:2], ADDR_WORDS);

  rr_arb2 u_rr_arb2 (
    .req_f  (f_req),
    .req_d  (d_req),
    .last_f (last_f),
    .gnt_f  (win_f),
    .gnt_d  (win_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      last_f  <= 1'b1;
      rsp_err <= 1'b0;
      rsp_wr  <= 1'b0;
    end else begin
      state   <= state_nx;
      last_f  <= last_f_nx;
      rsp_err <= rsp_err_nx;
      rsp_wr  <= rsp_wr_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    last_f_nx  = last_f;
    rsp_err_nx = rsp_err;
    rsp_wr_nx  = rsp_wr;
    f_gnt      = 1'b0;
    f_rvalid   = 1'b0;
    d_gnt      = 1'b0;
    d_done     = 1'b0;
    d_err      = 1'b0;
    rdata      = '0;
    mem_addr   = '0;
    mem_ren    = 1'b0;
    mem_wmask  = '0;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        // Reset also masks the grant path since state alone is already IDLE.
        if (!reset && win_f) begin
          f_gnt      = 1'b1;
          mem_addr   = f_addr[AW+1:2];
          mem_ren    = ~f_oor;
          rsp_err_nx = f_oor;
          rsp_wr_nx  = 1'b0;
          last_f_nx  = 1'b1;
          state_nx   = RESP_F;
        end else if (!reset && win_d) begin
          d_gnt      = 1'b1;
          mem_addr   = d_addr[AW+1:2];
          mem_ren    = ~d_oor & (d_wmask == 4'h0);
          if (!d_oor) begin
            mem_wmask = d_wmask;
            mem_wdata = (d_wmask != 4'h0) ? d_wdata : '0;
          end
          rsp_err_nx = d_oor;
          rsp_wr_nx  = (d_wmask != 4'h0);
          last_f_nx  = 1'b0;
          state_nx   = RESP_D;
        end
      end
      RESP_F: begin
        f_rvalid = 1'b1;
        rdata    = rsp_err ? '0 : mem_rdata;
        state_nx = IDLE;
      end
      RESP_D: begin
        d_done   = 1'b1;
        d_err    = rsp_err;
        rdata    = (rsp_err || rsp_wr) ? '0 : mem_rdata;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios followed by random
// traffic, all checked against a transaction-level model of the arbiter.
module tb_mem_arbiter;
  import riscv_pkg::*;

  localparam int unsigned WORDS = 4096;
  localparam int unsigned AWP   = 12;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           f_req = 1'b0;
  logic [31:0]    f_addr = '0;
  logic           f_gnt, f_rvalid;
  logic           d_req = 1'b0;
  logic [31:0]    d_addr = '0;
  logic [3:0]     d_wmask = '0;
  logic [31:0]    d_wdata = '0;
  logic           d_gnt, d_done, d_err;
  logic [31:0]    rdata;
  logic [AWP-1:0] mem_addr;
  logic           mem_ren;
  logic [3:0]     mem_wmask;
  logic [31:0]    mem_wdata;
  logic [31:0]    mem_rdata = '0;

  mem_arbiter #(.ADDR_WORDS(WORDS), .AW(AWP)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .d_req(d_req), .d_addr(d_addr), .d_wmask(d_wmask), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_err(d_err), .rdata(rdata),
    .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Environment RAM: synchronous read, byte-masked write.
  logic [31:0] ram [WORDS];
  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= ram[mem_addr];
    for (int b = 0; b < 4; b++)
      if (mem_wmask[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  function automatic logic [31:0] init_word(input int unsigned i);
    if (i == 2) return 32'h00100093;
    if (i == 4) return 32'h11223344;
    return (i * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // Reference model state
  typedef struct {
    bit          port_d;
    logic [31:0] data;
    bit          err;
    int unsigned due;
  } rsp_t;

  logic [31:0] shadow [WORDS];
  rsp_t        q[$];
  rsp_t        e;
  bit          m_busy;
  bit          m_last_f;
  int unsigned cyc;
  int          checks = 0;
  int          errors = 0;
  bit          f_gnt_q, d_gnt_q;
  bit          exp_f, exp_d, oor;
  int unsigned idx;
  logic [31:0] e_addr, e_wd;
  logic        e_ren;
  logic [3:0]  e_wm;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor and model, evaluated once per cycle away from the active edge.
  always @(negedge clk) begin
    cyc++;
    f_gnt_q = f_gnt;
    d_gnt_q = d_gnt;
    if (reset) begin
      chk("reset_ctl", {23'd0, f_gnt, f_rvalid, d_gnt, d_done, d_err, mem_ren, mem_wmask}, 32'd0);
      chk("reset_rdata", rdata, 32'd0);
      chk("reset_maddr", 32'(mem_addr), 32'd0);
      chk("reset_mwdata", mem_wdata, 32'd0);
      q.delete();
      m_busy   = 1'b0;
      m_last_f = 1'b1;
    end else begin
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk("rsp_f_rvalid", 32'(f_rvalid), 32'(!e.port_d));
        chk("rsp_d_done", 32'(d_done), 32'(e.port_d));
        chk("rsp_rdata", rdata, e.data);
        if (e.port_d) chk("rsp_d_err", 32'(d_err), 32'(e.err));
      end else begin
        chk("no_rsp", {30'd0, f_rvalid, d_done}, 32'd0);
      end

      exp_f = 1'b0; exp_d = 1'b0;
      if (!m_busy) begin
        if (f_req && d_req) begin
          exp_d = m_last_f;
          exp_f = !m_last_f;
        end else begin
          exp_f = f_req;
          exp_d = d_req;
        end
      end
      chk("gnt", {30'd0, f_gnt, d_gnt}, {30'd0, exp_f, exp_d});

      e_addr = '0; e_ren = 1'b0; e_wm = '0; e_wd = '0;
      if (exp_f || exp_d) begin
        logic [31:0] a;
        a      = exp_f ? f_addr : d_addr;
        oor    = (a >= WORDS * 4);
        idx    = (a % (WORDS * 4)) / 4;
        e_addr = idx;
        if (exp_f) begin
          e_ren = !oor;
          q.push_back('{port_d: 1'b0, data: oor ? 32'd0 : shadow[idx], err: 1'b0, due: cyc + 1});
          m_last_f = 1'b1;
        end else if (d_wmask != 4'h0) begin
          if (!oor) begin
            e_wm = d_wmask;
            e_wd = d_wdata;
            for (int b = 0; b < 4; b++)
              if (d_wmask[b]) shadow[idx][8*b +: 8] = d_wdata[8*b +: 8];
          end
          q.push_back('{port_d: 1'b1, data: 32'd0, err: oor, due: cyc + 1});
          m_last_f = 1'b0;
        end else begin
          e_ren = !oor;
          q.push_back('{port_d: 1'b1, data: oor ? 32'd0 : shadow[idx], err: oor, due: cyc + 1});
          m_last_f = 1'b0;
        end
        chk("mem_addr", 32'(mem_addr), e_addr);
        m_busy = 1'b1;
      end else begin
        m_busy = 1'b0;
      end
      chk("mem_ren", 32'(mem_ren), 32'(e_ren));
      chk("mem_wmask", 32'(mem_wmask), 32'(e_wm));
      chk("mem_wdata", mem_wdata, e_wd);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req_f_txn(input logic [31:0] a);
    int n = 0;
    tick();
    f_req = 1'b1; f_addr = a;
    do begin tick(); n++; end while (!f_gnt_q && n < 20);
    chk("f_gnt_timeout", 32'(f_gnt_q), 32'd1);
    f_req = 1'b0;
  endtask

  task automatic req_d_txn(input logic [31:0] a, input logic [3:0] wm, input logic [31:0] wd);
    int n = 0;
    tick();
    d_req = 1'b1; d_addr = a; d_wmask = wm; d_wdata = wd;
    do begin tick(); n++; end while (!d_gnt_q && n < 20);
    chk("d_gnt_timeout", 32'(d_gnt_q), 32'd1);
    d_req = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return 32'h4000 | ($urandom & 32'h3FF);
      1:       return 32'h8000_0000 | ($urandom & 32'hFF);
      default: return ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int unsigned i = 0; i < WORDS; i++) begin
      ram[i]    = init_word(i);
      shadow[i] = init_word(i);
    end
    repeat (3) tick();
    reset = 1'b0;

    // Fetch only
    req_f_txn(32'h8);
    @(negedge clk); #1;
    chk("fetch_rvalid", 32'(f_rvalid), 32'd1);
    chk("fetch_rdata", rdata, 32'h00100093);

    // Store then load
    req_d_txn(32'h10, 4'h3, 32'hAABBCCDD);
    @(negedge clk); #1;
    chk("store_done", {30'd0, d_done, d_err}, 32'd2);
    req_d_txn(32'h10, 4'h0, 32'h0);
    @(negedge clk); #1;
    chk("load_done", {30'd0, d_done, d_err}, 32'd2);
    chk("load_rdata", rdata, 32'h1122CCDD);

    // Out of range, both ports
    req_d_txn(32'h4000, 4'h0, 32'h0);
    @(negedge clk); #1;
    chk("oor_d_done", {30'd0, d_done, d_err}, 32'd3);
    chk("oor_d_rdata", rdata, 32'd0);
    req_f_txn(32'h4008);
    @(negedge clk); #1;
    chk("oor_f_rvalid", {30'd0, f_rvalid, d_err}, 32'd2);
    chk("oor_f_rdata", rdata, 32'd0);

    // Conflict held from reset: d, -, f, -, d, -, f, -
    tick();
    reset = 1'b1;
    f_req = 1'b1; f_addr = 32'h20;
    d_req = 1'b1; d_addr = 32'h24; d_wmask = 4'h0;
    repeat (2) tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("conflict_gnt", {30'd0, f_gnt_q, d_gnt_q},
          (i % 2 != 0) ? 32'd0 : (((i / 2) % 2 == 0) ? 32'd1 : 32'd2));
    end
    f_req = 1'b0; d_req = 1'b0;

    // Reset in the RESP_F cycle drops the response
    req_f_txn(32'h8);
    reset = 1'b1;
    f_req = 1'b1; f_addr = 32'h28;
    d_req = 1'b1; d_addr = 32'h2C; d_wmask = 4'h0;
    @(negedge clk); #1;
    chk("rst_mid_rvalid", 32'(f_rvalid), 32'd0);
    chk("rst_mid_rdata", rdata, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("rst_first_gnt", {30'd0, f_gnt_q, d_gnt_q}, 32'd1);
    f_req = 1'b0; d_req = 1'b0;
    repeat (3) tick();

    // Random traffic with occasional reset pulses
    for (int n = 0; n < 2000; n++) begin
      tick();
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 299) == 0) reset = 1'b1;
      if (!f_req || f_gnt_q) begin
        f_req = ($urandom_range(0, 2) != 0);
        if (f_req) f_addr = rand_addr();
      end
      if (!d_req || d_gnt_q) begin
        d_req = ($urandom_range(0, 2) != 0);
        if (d_req) begin
          d_addr  = rand_addr();
          d_wmask = $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'h0;
          d_wdata = $urandom;
        end
      end
    end
    reset = 1'b0;
    f_req = 1'b0; d_req = 1'b0;
    repeat (4) tick();
    chk("queue_drained", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
